// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational product.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            mul_en_i,
  input  logic            rs1_sign_i,
  input  logic            rs2_sign_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  output logic [XLEN-1:0] data_1_o,
  output logic [XLEN-1:0] data_2_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt;
  logic                mul_q, neg_q, neg_r;
  logic [XLEN-1:0]     opa, opb;
  logic [2*XLEN-1:0]   acc, acc_nxt;

  logic                rs1_neg, rs2_neg;
  logic [XLEN-1:0]     rs1_abs, rs2_abs;
  logic                accept, div_zero, div_ovf, skip_calc, last;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic                q_bit;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix;

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  // Only a flagged-signed operand with its top bit set is treated as negative.
  assign rs1_neg = rs1_sign_i & rs1_data_i[XLEN-1];
  assign rs2_neg = rs2_sign_i & rs2_data_i[XLEN-1];
  assign rs1_abs = rs1_neg ? neg_word(rs1_data_i) : rs1_data_i;
  assign rs2_abs = rs2_neg ? neg_word(rs2_data_i) : rs2_data_i;

  assign accept   = (state == IDLE) & req_valid_i & ~flush_i;
  assign div_zero = ~mul_en_i & (rs2_data_i == '0);
  assign div_ovf  = ~mul_en_i & rs1_sign_i & rs2_sign_i & (&rs2_data_i)
                  & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}});
  assign last     = (cnt == CW'(XLEN-1));

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{rs1_neg}}, rs1_data_i};
  assign fast_b    = {{XLEN{rs2_neg}}, rs2_data_i};
  assign fast_prod = fast_a * fast_b;
  assign skip_calc = div_zero | div_ovf | mul_en_i;
`else
  assign skip_calc = div_zero | div_ovf;
`endif

  // One iteration: multiply adds |rs1| to the high half and shifts right;
  // divide shifts the dividend MSB into a 65-bit trial subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb};
    q_bit     = ~div_diff[XLEN];
    if (mul_q)
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else
      acc_nxt = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], q_bit};
    prod_fix = neg_q ? neg_dword(acc_nxt) : acc_nxt;
    quo_fix  = neg_q ? neg_word(acc_nxt[XLEN-1:0]) : acc_nxt[XLEN-1:0];
    rem_fix  = neg_r ? neg_word(acc_nxt[2*XLEN-1:XLEN]) : acc_nxt[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = skip_calc ? DONE : CALC;
      CALC: begin
        if (flush_i)   state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mul_q    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      data_1_o <= '0;
      data_2_o <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mul_q <= mul_en_i;
      neg_q <= rs1_neg ^ rs2_neg;
      neg_r <= rs1_neg;
      opa   <= rs1_abs;
      opb   <= rs2_abs;
      acc   <= mul_en_i ? {{XLEN{1'b0}}, rs2_abs} : {{XLEN{1'b0}}, rs1_abs};
      if (div_zero) begin
        data_1_o <= '1;
        data_2_o <= rs1_data_i;
      end else if (div_ovf) begin
        data_1_o <= rs1_data_i;
        data_2_o <= '0;
      end
`ifdef MULDIV_FAST_MUL_EN
      else if (mul_en_i) begin
        {data_2_o, data_1_o} <= fast_prod;
      end
`endif
    end else if ((state == CALC) && !flush_i) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        if (mul_q) begin
          {data_2_o, data_1_o} <= prod_fix;
        end else begin
          data_1_o <= quo_fix;
          data_2_o <= rem_fix;
        end
      end
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign resp_valid_o = (state == DONE) & ~flush_i;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV64M cases, randomized operands against an
// arithmetic reference model, flush, async reset and held-request behaviour.
module tb_muldiv_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, mul_en, rs1_sign, rs2_sign, flush;
  logic [63:0] rs1, rs2, data_1, data_2;
  logic        resp_valid, busy;

  int          tests = 0;
  int          failed = 0;
  int          resp_cnt = 0;
  int          exp_pulses = 0;
  int          edges;
  logic [127:0] last_exp = '0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  muldiv_unit #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .mul_en_i     (mul_en),
    .rs1_sign_i   (rs1_sign),
    .rs2_sign_i   (rs2_sign),
    .rs1_data_i   (rs1),
    .rs2_data_i   (rs2),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .data_1_o     (data_1),
    .data_2_o     (data_2),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-width two's-complement product, truncating signed division.
  function automatic logic [127:0] model(input logic m, s1, s2, input logic [63:0] a, b);
    logic [127:0]       wa, wb;
    logic signed [65:0] da, db;
    logic [63:0]        q, r;
    if (m) begin
      wa = {{64{s1 & a[63]}}, a};
      wb = {{64{s2 & b[63]}}, b};
      return wa * wb;
    end
    if (b == 64'd0) return {a, ONES};
    da = {{2{s1 & a[63]}}, a};
    db = {{2{s2 & b[63]}}, b};
    q  = 64'(da / db);
    r  = 64'(da % db);
    return {r, q};
  endfunction

  function automatic int exp_latency(input logic m, s1, s2, input logic [63:0] a, b);
    if (m) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 65;
`endif
    end
    if (b == 64'd0) return 1;
    if (s1 && s2 && a == MINV && b == ONES) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return MINV;
      2:       return ONES;
      3:       return 64'($urandom_range(0, 20));
      4:       return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input logic m, s1, s2, input logic [63:0] a, b,
                        input logic [127:0] exp, input string tag);
    int n;
    mul_en = m; rs1_sign = s1; rs2_sign = s2; rs1 = a; rs2 = b;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(exp_latency(m, s1, s2, a, b)));
    chk({tag, "_d1"}, {64'd0, data_1}, {64'd0, exp[63:0]});
    chk({tag, "_d2"}, {64'd0, data_2}, {64'd0, exp[127:64]});
    last_exp = exp;
    exp_pulses++;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {127'd0, resp_valid}, 128'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; mul_en = 1'b0; rs1_sign = 1'b0; rs2_sign = 1'b0;
    rs1 = '0; rs2 = '0; flush = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {127'd0, req_ready}, 128'd1);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_resp", {127'd0, resp_valid}, 128'd0);
    chk("rst_data", {data_2, data_1}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    run_op(1, 1, 1, -64'd3, 64'd7, {ONES, 64'hFFFF_FFFF_FFFF_FFEB}, "mul_ss");
    run_op(1, 1, 0, ONES, 64'd2, {ONES, 64'hFFFF_FFFF_FFFF_FFFE}, "mulhsu");
    run_op(1, 0, 0, ONES, 64'd2, {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}, "mulhu");
    run_op(0, 1, 1, -64'd7, 64'd2, {ONES, 64'hFFFF_FFFF_FFFF_FFFD}, "div_s");
    run_op(0, 1, 1, -64'd7, -64'd2, {ONES, 64'd3}, "div_nn");
    run_op(0, 0, 0, 64'd100, 64'd7, {64'd2, 64'd14}, "divu");
    run_op(0, 0, 0, 64'h1234, 64'd0, {64'h1234, ONES}, "div0");
    run_op(0, 1, 1, -64'd5, 64'd0, {-64'd5, ONES}, "div0_s");
    run_op(0, 1, 1, MINV, ONES, {64'd0, MINV}, "ovf");
    run_op(0, 0, 0, MINV, ONES, {MINV, 64'd0}, "divu_big");

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      logic m, s1, s2;
      logic [63:0] a, b;
      m  = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a  = pick();
      b  = pick();
      run_op(m, s1, s2, a, b, model(m, s1, s2, a, b), $sformatf("rnd%0d", i));
    end

    // Flush at counter 30 discards the operation and keeps the previous result
    mul_en = 1'b0; rs1_sign = 1'b1; rs2_sign = 1'b1; rs1 = -64'd1000; rs2 = 64'd3;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("fl_busy_pre", {127'd0, busy}, 128'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy", {127'd0, busy}, 128'd0);
    chk("fl_resp", {127'd0, resp_valid}, 128'd0);
    chk("fl_data", {data_2, data_1}, last_exp);
    run_op(0, 1, 1, -64'd1000, 64'd3, {-64'd1, -64'd333}, "post_fl");

    // Flush coincident with a request in IDLE: nothing is accepted
    mul_en = 1'b1; rs1_sign = 1'b0; rs2_sign = 1'b0; rs1 = 64'd5; rs2 = 64'd6;
    req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("fl_coinc_busy", {127'd0, busy}, 128'd0);

    // Request held through busy is accepted exactly once more, two edges after completion
    mul_en = 1'b0; rs1_sign = 1'b0; rs2_sign = 1'b0; rs1 = 64'd100; rs2 = 64'd7;
    req_valid = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    while (!resp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("hold_lat", 128'(edges), 128'd65);
    exp_pulses++;
    @(posedge clk); #1;
    chk("hold_idle", {126'd0, busy, req_ready}, 128'd1);
    @(posedge clk); #1;
    chk("hold_accept", {127'd0, busy}, 128'd1);
    req_valid = 1'b0;
    edges = 1;
    while (!resp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("hold2_lat", 128'(edges), 128'd65);
    chk("hold2_data", {data_2, data_1}, {64'd2, 64'd14});
    exp_pulses++;
    repeat (70) @(posedge clk);
    #1;
    chk("hold_once", 128'(resp_cnt), 128'(exp_pulses));

    // Asynchronous reset mid-calculation
    mul_en = 1'b0; rs1_sign = 1'b0; rs2_sign = 1'b0; rs1 = 64'd999; rs2 = 64'd10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", {data_2, data_1}, 128'd0);
    chk("arst_ctl", {125'd0, busy, req_ready, resp_valid}, 128'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(1, 1, 0, -64'd2, 64'd3, {ONES, -64'd6}, "post_rst");

    chk("pulse_total", 128'(resp_cnt), 128'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
